// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by a one-cycle tick strobe.
// The counter has start/stop run control, clear and parallel load, and drives a registered count and a wrap pulse.
//
// state      | meaning
// -----------+-------------------------------------------
// ST_STOPPED | ticks ignored, count holds
// ST_RUNNING | each tick steps the count up or down
module bcd_tick_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  wrap
);

    typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [4*DIGITS-1:0] step_val;
    logic                step_wrap;
    logic [4*DIGITS-1:0] load_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOPPED;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Stop has priority over start when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: if (start && !stop) state_d = ST_RUNNING;
            ST_RUNNING: if (stop)           state_d = ST_STOPPED;
            default:                        state_d = ST_STOPPED;
        endcase
    end

    // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        step_val = count_q;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (dig >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    always_comb begin
        load_sat = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_sat;
        end else if (tick && state_q == ST_RUNNING) begin
            count_d = step_val;
            wrap_d  = step_wrap;
        end
    end

    assign count   = count_q;
    assign running = (state_q == ST_RUNNING);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter (DIGITS=4): a decimal reference model pushes expected results per cycle,
// and the bench pops and compares them after each clock edge.
module tb_bcd_tick_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1, tick = 1'b0, start = 1'b0, stop = 1'b0, up = 1'b1;
    logic        clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        running, wrap;

    bcd_tick_counter #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .up(up),
        .clr(clr), .load(load), .load_val(load_val),
        .count(count), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic        r;
        logic        w;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;
    int   m_val  = 0;
    logic m_run  = 1'b0;

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            int n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic cyc(input logic r, input logic t, input logic sa, input logic so,
                       input logic u, input logic c, input logic l, input logic [15:0] lv);
        exp_t e;
        int   nv;
        logic nw;
        rst = r; tick = t; start = sa; stop = so; up = u; clr = c; load = l; load_val = lv;
        nv = m_val;
        nw = 1'b0;
        if (r) begin
            nv = 0;
            m_run = 1'b0;
        end else begin
            if (c) nv = 0;
            else if (l) nv = bcd2int(lv);
            else if (t && m_run) begin
                if (u) begin
                    nw = (m_val == 9999);
                    nv = (m_val + 1) % 10000;
                end else begin
                    nw = (m_val == 0);
                    nv = (m_val + 9999) % 10000;
                end
            end
            if (so) m_run = 1'b0;
            else if (sa) m_run = 1'b1;
        end
        m_val = nv;
        e.c = int2bcd(nv);
        e.r = m_run;
        e.w = nw;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            $error("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sb_q.pop_front();
            check16("count", count, e.c);
            check1("running", running, e.r);
            check1("wrap", wrap, e.w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, up, 0, 0, 16'h0);
    endtask

    task automatic ticks(input int n, input logic u);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, u, 0, 0, 16'h0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset then idle ticks without start.
        cyc(1, 0, 0, 0, 1, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 1, 0, 0, 16'h0);
        check16("reset_count", count, 16'h0000);
        check1("reset_running", running, 1'b0);
        ticks(10, 1);
        check16("idle_ticks", count, 16'h0000);

        // Carry chain.
        cyc(0, 0, 1, 0, 1, 0, 1, 16'h0999);
        ticks(1, 1);
        check16("carry_chain", count, 16'h1000);
        check1("carry_no_wrap", wrap, 1'b0);

        // Up wrap.
        cyc(0, 0, 0, 0, 1, 0, 1, 16'h9998);
        ticks(1, 1);
        check16("up_9999", count, 16'h9999);
        ticks(1, 1);
        check16("up_wrap_count", count, 16'h0000);
        check1("up_wrap_pulse", wrap, 1'b1);
        idle(1);
        check1("up_wrap_single", wrap, 1'b0);

        // Down wrap and borrow chain.
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0001);
        ticks(2, 0);
        check16("down_wrap_count", count, 16'h9999);
        check1("down_wrap_pulse", wrap, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h1000);
        ticks(1, 0);
        check16("borrow_chain", count, 16'h0999);

        // Collisions.
        cyc(0, 0, 1, 1, 1, 0, 0, 16'h0);
        check1("start_stop", running, 1'b0);
        cyc(0, 1, 1, 0, 1, 0, 1, 16'h0005);
        check16("start_tick_ignored", count, 16'h0005);
        cyc(0, 1, 0, 1, 1, 0, 0, 16'h0);
        check16("stop_tick_counted", count, 16'h0006);
        cyc(0, 0, 1, 0, 1, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 1, 0, 1, 16'h1234);
        check16("load_with_tick", count, 16'h1234);
        cyc(0, 0, 0, 0, 1, 1, 1, 16'h5555);
        check16("clr_over_load", count, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0, 1, 16'hAF3C);
        check16("load_saturate", count, 16'h9939);
        cyc(0, 0, 0, 0, 1, 0, 1, 16'h9999);
        ticks(1, 1);
        cyc(0, 1, 0, 0, 1, 1, 0, 16'h0);
        check1("clr_no_wrap", wrap, 1'b0);

        // Reset mid-run.
        cyc(0, 0, 0, 0, 1, 0, 1, 16'h4321);
        check1("pre_rst_running", running, 1'b1);
        cyc(1, 1, 0, 0, 1, 0, 0, 16'h0);
        check16("rst_tick_count", count, 16'h0000);
        check1("rst_running", running, 1'b0);
        ticks(3, 1);
        check16("after_rst_ticks", count, 16'h0000);

        // Mixed pseudo-random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] lv;
            lv = 16'($urandom);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                1'($urandom), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 14) == 0), lv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Multi-digit BCD up/down counter advanced by the one-cycle `tick` strobe from the clock divider stage.
- Shares the divider's fast `clk`; `tick` is an enable pulse, not a clock.
- Provides start/stop run control, synchronous clear and parallel load.
- Feeds the display/readout stage with a registered packed-BCD value and a wrap strobe for cascading.

Parameters:
- DIGITS, 4, number of BCD digits (>=1); count width is 4*DIGITS.

Ports:
- clk  input  1  system clock (same clock as the divider).
- rst  input  1  reset; synchronous, active-high, one clock.
- tick  input  1  one-cycle advance strobe from the divider; sampled on rising clk.
- start  input  1  pulse; sets run state.
- stop  input  1  pulse; clears run state.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle.
- clr  input  1  synchronous clear of count.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  packed BCD load value; digit 0 is in [3:0].
- count  output  4*DIGITS  packed BCD count; registered.
- running  output  1  run state; registered.
- wrap  output  1  one-cycle pulse on wrap-around; registered.

Behaviour:
- All state updates on rising clk. No asynchronous paths. Every output is a register.

Reset (rst=1, highest priority over every other input):
- count=0, running=0, wrap=0.

Run state FSM (two states):
- STOPPED -> RUNNING on start.
- RUNNING -> STOPPED on stop.
- start and stop in the same cycle: stop wins, so the next state is STOPPED.
- running is 1 exactly in RUNNING.
- clr and load do not change the run state.

Count priority per cycle:
- rst > clr > load > (tick & running) > hold.
- clr: count=0, wrap=0.
- load: each digit is taken from load_val. Any digit >9 is saturated to 9. wrap=0.
- tick & running & up:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit (ripple, same cycle).
  - All digits 9 -> all 0, wrap=1 for one cycle.
- tick & running & !up:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, wrap=1 for one cycle.
- tick while STOPPED: ignored; count holds, wrap=0.

Timing and latency:
- count reflects a tick one clk after the tick cycle. wrap asserts in that same cycle as the wrapped count.
- A start and a tick in the same cycle: the tick is ignored, because the state is still STOPPED when sampled. Counting begins with the next tick.
- A stop and a tick in the same cycle: the tick is counted, because the state is still RUNNING when sampled.
- A load or clr coincident with a tick: the tick is dropped, not deferred.
- wrap is 0 in every cycle except the one following a wrapping tick.
- It never asserts on load or clr, even when count passes through the wrap value.
- Back-to-back ticks (tick held high): one step per clk. No minimum spacing is required.

Arithmetic:
- Pure BCD per digit. No binary intermediate wider than 4 bits per digit.
- Carry/borrow chain is combinational across DIGITS.

Reset mid-operation:
- Any state returns to count=0, STOPPED, wrap=0 on the next clk edge.
- A tick coincident with rst is discarded.

Test Plan (DIGITS=4):
- Reset then idle: rst 2 cycles, 10 ticks with no start -> count=0x0000, running=0, wrap never 1.
- Carry chain: load 0x0999, start, up=1, one tick -> count=0x1000 one clk later, wrap=0.
- Up wrap: load 0x9998, start, up=1, 2 ticks -> count 0x9999 then 0x0000. wrap=1 for exactly the clk with 0x0000.
- Down wrap: load 0x0001, start, up=0, 2 ticks -> count 0x0000 then 0x9999, with a single-cycle wrap. Also load 0x1000, one tick -> 0x0999.
- Priority and collisions:
  - start+stop same cycle -> running=0.
  - stop+tick on count 0x0005 (up) -> 0x0006.
  - load 0x1234 with tick -> 0x1234.
  - clr with load -> 0x0000.
  - load 0xAF3C -> 0x9939.
- Reset mid-run: running with count 0x4321, assert rst coincident with tick -> next clk count=0x0000, running=0, wrap=0. Subsequent ticks are ignored until start.
